// File: rtl/control_unit_if.sv
`timescale 1ns/1ps
// Control bundle between the sequencer and the CPU datapath: IR/condition/memory
// status flowing in, one cycle's worth of bus selects, loads and strobes flowing out.
interface control_unit_if #(
    parameter int ALUW = 4
);
    logic [31:0]     ir;
    logic            con_ff;
    logic            mem_ready;

    logic            Gra, Grb, Grc, Rin, Rout, BAout;
    logic            PCout, MDRout, Zhighout, Zlowout, HIout, LOout, InPortout, Cout;
    logic            PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, OutPortin, CONin;
    logic            IncPC, Read, Write;
    logic [ALUW-1:0] alu_op;
    logic            run;

    modport master (
        input  ir, con_ff, mem_ready,
        output Gra, Grb, Grc, Rin, Rout, BAout,
        output PCout, MDRout, Zhighout, Zlowout, HIout, LOout, InPortout, Cout,
        output PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, OutPortin, CONin,
        output IncPC, Read, Write, alu_op, run
    );

    modport slave (
        output ir, con_ff, mem_ready,
        input  Gra, Grb, Grc, Rin, Rout, BAout,
        input  PCout, MDRout, Zhighout, Zlowout, HIout, LOout, InPortout, Cout,
        input  PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, OutPortin, CONin,
        input  IncPC, Read, Write, alu_op, run
    );
endinterface

// File: rtl/control_unit.sv
`timescale 1ns/1ps
// Fetch/decode/execute sequencer for the CPU datapath. Opcodes are grouped into
// classes that share a step pattern; strobes are decoded from the step register.
module control_unit #(
    parameter int OPW  = 5,
    parameter int ALUW = 4
) (
    input  logic           clk,
    input  logic           reset,
    control_unit_if.master cu
);

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_REG, C_IMM, C_MULDIV, C_UNARY, C_LDI, C_LD, C_ST, C_BR,
        C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
    } cls_t;

    function automatic cls_t op_class(input logic [OPW-1:0] op);
        case (op)
            5'd0:                          op_class = C_LD;
            5'd1:                          op_class = C_LDI;
            5'd2:                          op_class = C_ST;
            5'd3, 5'd4, 5'd5, 5'd6,
            5'd7, 5'd8, 5'd9, 5'd10:       op_class = C_REG;
            5'd11, 5'd12, 5'd13:           op_class = C_IMM;
            5'd14, 5'd15:                  op_class = C_MULDIV;
            5'd16, 5'd17:                  op_class = C_UNARY;
            5'd18:                         op_class = C_BR;
            5'd19:                         op_class = C_JR;
            5'd20:                         op_class = C_JAL;
            5'd21:                         op_class = C_IN;
            5'd22:                         op_class = C_OUT;
            5'd23:                         op_class = C_MFHI;
            5'd24:                         op_class = C_MFLO;
            5'd25:                         op_class = C_NOP;
            default:                       op_class = C_HALT;
        endcase
    endfunction

    // Address-forming ops (ld/ldi/st/br/addi) fall through to ADD.
    function automatic logic [ALUW-1:0] alu_code(input logic [OPW-1:0] op);
        case (op)
            5'd4:         alu_code = 4'd1;
            5'd5:         alu_code = 4'd4;
            5'd6:         alu_code = 4'd5;
            5'd7:         alu_code = 4'd6;
            5'd8:         alu_code = 4'd7;
            5'd9, 5'd12:  alu_code = 4'd8;
            5'd10, 5'd13: alu_code = 4'd9;
            5'd14:        alu_code = 4'd2;
            5'd15:        alu_code = 4'd3;
            5'd16:        alu_code = 4'd10;
            5'd17:        alu_code = 4'd11;
            default:      alu_code = 4'd0;
        endcase
    endfunction

    state_t          state_r, next_s;
    logic            t1_first_r;
    cls_t            cls_s;
    logic [ALUW-1:0] alu_s;

    assign cls_s = op_class(cu.ir[31 -: OPW]);
    assign alu_s = alu_code(cu.ir[31 -: OPW]);

    // Step register; t1_first_r marks the first T1 cycle so PC loads only once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= S_RST;
            t1_first_r <= 1'b0;
        end else begin
            state_r    <= next_s;
            t1_first_r <= (next_s == S_T1) && (state_r != S_T1);
        end
    end

    // Next step and per-step strobe decode.
    always_comb begin
        next_s       = S_RST;
        cu.Gra       = 1'b0; cu.Grb      = 1'b0; cu.Grc       = 1'b0;
        cu.Rin       = 1'b0; cu.Rout     = 1'b0; cu.BAout     = 1'b0;
        cu.PCout     = 1'b0; cu.MDRout   = 1'b0; cu.Zhighout  = 1'b0;
        cu.Zlowout   = 1'b0; cu.HIout    = 1'b0; cu.LOout     = 1'b0;
        cu.InPortout = 1'b0; cu.Cout     = 1'b0; cu.PCin      = 1'b0;
        cu.IRin      = 1'b0; cu.MARin    = 1'b0; cu.MDRin     = 1'b0;
        cu.Yin       = 1'b0; cu.Zin      = 1'b0; cu.HIin      = 1'b0;
        cu.LOin      = 1'b0; cu.OutPortin = 1'b0; cu.CONin    = 1'b0;
        cu.IncPC     = 1'b0; cu.Read     = 1'b0; cu.Write     = 1'b0;
        cu.alu_op    = 4'd0;
        cu.run       = (state_r != S_RST) && (state_r != S_HALT);
        case (state_r)
            S_RST: next_s = S_T0;
            S_T0: begin
                next_s = S_T1;
                cu.PCout = 1'b1; cu.MARin = 1'b1; cu.IncPC = 1'b1; cu.Zin = 1'b1;
            end
            S_T1: begin
                next_s = cu.mem_ready ? S_T2 : S_T1;
                cu.Zlowout = 1'b1; cu.PCin = t1_first_r; cu.Read = 1'b1; cu.MDRin = 1'b1;
            end
            S_T2: begin
                next_s = S_T3;
                cu.MDRout = 1'b1; cu.IRin = 1'b1;
            end
            S_T3: begin
                case (cls_s)
                    C_HALT:                                   next_s = S_HALT;
                    C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP: next_s = S_T0;
                    default:                                  next_s = S_T4;
                endcase
                case (cls_s)
                    C_REG, C_IMM:      begin cu.Grb = 1'b1; cu.Rout = 1'b1; cu.Yin = 1'b1; end
                    C_MULDIV:          begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.Yin = 1'b1; end
                    C_UNARY:           begin cu.Grb = 1'b1; cu.Rout = 1'b1; cu.alu_op = alu_s; cu.Zin = 1'b1; end
                    C_LDI, C_LD, C_ST: begin cu.Grb = 1'b1; cu.BAout = 1'b1; cu.Yin = 1'b1; end
                    C_BR:              begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.CONin = 1'b1; end
                    C_JR:              begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.PCin = 1'b1; end
                    C_JAL:             begin cu.PCout = 1'b1; cu.Grb = 1'b1; cu.Rin = 1'b1; end
                    C_IN:              begin cu.InPortout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; end
                    C_OUT:             begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.OutPortin = 1'b1; end
                    C_MFHI:            begin cu.HIout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; end
                    C_MFLO:            begin cu.LOout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; end
                    default:           cu.run = 1'b1;
                endcase
            end
            S_T4: begin
                case (cls_s)
                    C_UNARY, C_JAL: next_s = S_T0;
                    C_HALT:         next_s = S_HALT;
                    default:        next_s = S_T5;
                endcase
                case (cls_s)
                    C_REG:             begin cu.Grc = 1'b1; cu.Rout = 1'b1; cu.alu_op = alu_s; cu.Zin = 1'b1; end
                    C_IMM:             begin cu.Cout = 1'b1; cu.alu_op = alu_s; cu.Zin = 1'b1; end
                    C_MULDIV:          begin cu.Grb = 1'b1; cu.Rout = 1'b1; cu.alu_op = alu_s; cu.Zin = 1'b1; end
                    C_UNARY:           begin cu.Zlowout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; end
                    C_LDI, C_LD, C_ST: begin cu.Cout = 1'b1; cu.Zin = 1'b1; end
                    C_BR:              begin cu.PCout = 1'b1; cu.Yin = 1'b1; end
                    C_JAL:             begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.PCin = 1'b1; end
                    default:           cu.run = 1'b1;
                endcase
            end
            S_T5: begin
                case (cls_s)
                    C_MULDIV, C_LD, C_ST, C_BR: next_s = S_T6;
                    default:                    next_s = S_T0;
                endcase
                case (cls_s)
                    C_REG, C_IMM, C_LDI: begin cu.Zlowout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; end
                    C_MULDIV:            begin cu.Zlowout = 1'b1; cu.LOin = 1'b1; end
                    C_LD, C_ST:          begin cu.Zlowout = 1'b1; cu.MARin = 1'b1; end
                    C_BR:                begin cu.Cout = 1'b1; cu.Zin = 1'b1; end
                    default:             cu.run = 1'b1;
                endcase
            end
            S_T6: begin
                case (cls_s)
                    C_LD:    next_s = cu.mem_ready ? S_T7 : S_T6;
                    C_ST:    next_s = S_T7;
                    default: next_s = S_T0;
                endcase
                case (cls_s)
                    C_MULDIV: begin cu.Zhighout = 1'b1; cu.HIin = 1'b1; end
                    C_LD:     begin cu.Read = 1'b1; cu.MDRin = 1'b1; end
                    C_ST:     begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.MDRin = 1'b1; end
                    C_BR:     begin cu.Zlowout = cu.con_ff; cu.PCin = cu.con_ff; end
                    default:  cu.run = 1'b1;
                endcase
            end
            S_T7: begin
                case (cls_s)
                    C_ST:    next_s = cu.mem_ready ? S_T0 : S_T7;
                    default: next_s = S_T0;
                endcase
                case (cls_s)
                    C_LD:    begin cu.MDRout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; end
                    C_ST:    cu.Write = 1'b1;
                    default: cu.run = 1'b1;
                endcase
            end
            S_HALT:  next_s = S_HALT;
            default: next_s = S_RST;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
`timescale 1ns/1ps
// Directed and randomized instruction streams checked cycle by cycle against
// per-instruction step lists derived from the opcode tables.
module tb_control_unit;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    control_unit_if #(.ALUW(4)) cu ();
    control_unit #(.OPW(5), .ALUW(4)) dut (.clk(clk), .reset(reset), .cu(cu));

    localparam logic [26:0] GRA = 27'h1,       GRB = 27'h2,        GRC = 27'h4,
                            RIN = 27'h8,       ROUT = 27'h10,      BAOUT = 27'h20,
                            PCOUT = 27'h40,    MDROUT = 27'h80,    ZHI = 27'h100,
                            ZLO = 27'h200,     HIOUT = 27'h400,    LOOUT = 27'h800,
                            INPO = 27'h1000,   COUT = 27'h2000,    PCIN = 27'h4000,
                            IRIN = 27'h8000,   MARIN = 27'h10000,  MDRIN = 27'h20000,
                            YIN = 27'h40000,   ZIN = 27'h80000,    HIIN = 27'h100000,
                            LOIN = 27'h200000, OUTPIN = 27'h400000, CONIN = 27'h800000,
                            INCPC = 27'h1000000, READ = 27'h2000000, WRITE = 27'h4000000;

    logic [26:0] m_obs;
    assign m_obs = {cu.Write, cu.Read, cu.IncPC, cu.CONin, cu.OutPortin, cu.LOin, cu.HIin,
                    cu.Zin, cu.Yin, cu.MDRin, cu.MARin, cu.IRin, cu.PCin, cu.Cout,
                    cu.InPortout, cu.LOout, cu.HIout, cu.Zlowout, cu.Zhighout, cu.MDRout,
                    cu.PCout, cu.BAout, cu.Rout, cu.Rin, cu.Grc, cu.Grb, cu.Gra};

    int vectors = 0;
    int miscompares = 0;

    logic [26:0] q_m[$];
    logic [3:0]  q_a[$];
    bit          q_mem[$];
    logic [3:0]  reg_alu[8] = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
    logic [3:0]  imm_alu[3] = '{4'd0, 4'd8, 4'd9};

    task automatic chk(input string tag, input logic [26:0] m, input logic [3:0] a, input logic r);
        logic [31:0] obs, exp;
        obs = {m_obs, cu.alu_op, cu.run};
        exp = {m, a, r};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed strobes/alu/run %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void push(input logic [26:0] m, input logic [3:0] a, input bit mem);
        q_m.push_back(m);
        q_a.push_back(a);
        q_mem.push_back(mem);
    endfunction

    // Execute-phase step list for one instruction, straight from the opcode tables.
    function automatic void build(input logic [4:0] op, input bit con);
        int o;
        o = int'(op);
        q_m.delete(); q_a.delete(); q_mem.delete();
        if (o >= 3 && o <= 13) begin
            push(GRB | ROUT | YIN, 4'd0, 1'b0);
            if (o <= 10) push(GRC | ROUT | ZIN, reg_alu[o-3], 1'b0);
            else         push(COUT | ZIN, imm_alu[o-11], 1'b0);
            push(ZLO | GRA | RIN, 4'd0, 1'b0);
        end else if (o == 14 || o == 15) begin
            push(GRA | ROUT | YIN, 4'd0, 1'b0);
            push(GRB | ROUT | ZIN, (o == 14) ? 4'd2 : 4'd3, 1'b0);
            push(ZLO | LOIN, 4'd0, 1'b0);
            push(ZHI | HIIN, 4'd0, 1'b0);
        end else if (o == 16 || o == 17) begin
            push(GRB | ROUT | ZIN, (o == 16) ? 4'd10 : 4'd11, 1'b0);
            push(ZLO | GRA | RIN, 4'd0, 1'b0);
        end else if (o <= 2) begin
            push(GRB | BAOUT | YIN, 4'd0, 1'b0);
            push(COUT | ZIN, 4'd0, 1'b0);
            if (o == 1) push(ZLO | GRA | RIN, 4'd0, 1'b0);
            else        push(ZLO | MARIN, 4'd0, 1'b0);
            if (o == 0) begin
                push(READ | MDRIN, 4'd0, 1'b1);
                push(MDROUT | GRA | RIN, 4'd0, 1'b0);
            end else if (o == 2) begin
                push(GRA | ROUT | MDRIN, 4'd0, 1'b0);
                push(WRITE, 4'd0, 1'b1);
            end
        end else if (o == 18) begin
            push(GRA | ROUT | CONIN, 4'd0, 1'b0);
            push(PCOUT | YIN, 4'd0, 1'b0);
            push(COUT | ZIN, 4'd0, 1'b0);
            push(con ? (ZLO | PCIN) : 27'h0, 4'd0, 1'b0);
        end else if (o == 19) push(GRA | ROUT | PCIN, 4'd0, 1'b0);
        else if (o == 20) begin
            push(PCOUT | GRB | RIN, 4'd0, 1'b0);
            push(GRA | ROUT | PCIN, 4'd0, 1'b0);
        end
        else if (o == 21) push(INPO | GRA | RIN, 4'd0, 1'b0);
        else if (o == 22) push(GRA | ROUT | OUTPIN, 4'd0, 1'b0);
        else if (o == 23) push(HIOUT | GRA | RIN, 4'd0, 1'b0);
        else if (o == 24) push(LOOUT | GRA | RIN, 4'd0, 1'b0);
        else push(27'h0, 4'd0, 1'b0);
    endfunction

    task automatic check_halt(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            chk(tag, 27'h0, 4'd0, 1'b0);
            cu.mem_ready = 1'($urandom);
            cu.con_ff    = 1'($urandom);
            step();
        end
    endtask

    // Entered with the DUT in T0; returns with it in T0 again (or halted).
    task automatic run_instr(input string tag, input logic [4:0] op, input logic [26:0] fields,
                             input bit con, input int fw, input int mw);
        int reps;
        cu.ir     = {op, fields};
        cu.con_ff = con;
        build(op, con);
        chk({tag, ":T0"}, PCOUT | MARIN | INCPC | ZIN, 4'd0, 1'b1);
        step();
        for (int w = 0; w <= fw; w++) begin
            chk({tag, ":T1"}, ZLO | READ | MDRIN | ((w == 0) ? PCIN : 27'h0), 4'd0, 1'b1);
            cu.mem_ready = (w == fw);
            step();
        end
        chk({tag, ":T2"}, MDROUT | IRIN, 4'd0, 1'b1);
        step();
        for (int k = 0; k < q_m.size(); k++) begin
            reps = q_mem[k] ? mw : 0;
            for (int w = 0; w <= reps; w++) begin
                chk($sformatf("%s:X%0d", tag, k), q_m[k], q_a[k], 1'b1);
                cu.mem_ready = (w == reps);
                step();
            end
        end
        if (op >= 5'd26) check_halt({tag, ":halt"}, 10);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
        step();
    endtask

    initial begin
        logic [4:0] rop;
        reset = 1'b0;
        cu.ir = 32'h0;
        cu.con_ff = 1'b0;
        cu.mem_ready = 1'b0;
        step();
        chk("reset_state", 27'h0, 4'd0, 1'b0);
        step();
        chk("reset_hold", 27'h0, 4'd0, 1'b0);

        // Reset asserted while a fetch Read is pending.
        release_reset();
        chk("pre_rst:T0", PCOUT | MARIN | INCPC | ZIN, 4'd0, 1'b1);
        cu.mem_ready = 1'b0;
        step();
        chk("pre_rst:T1", ZLO | READ | MDRIN | PCIN, 4'd0, 1'b1);
        #2 reset = 1'b0;
        #1 chk("rst_mid_read", 27'h0, 4'd0, 1'b0);
        release_reset();

        run_instr("add", 5'd3, 27'h2B8000, 1'b0, 2, 0);
        run_instr("mul", 5'd14, 27'($urandom), 1'b0, 0, 0);
        run_instr("ld", 5'd0, 27'($urandom), 1'b0, 0, 1);
        run_instr("st", 5'd2, 27'($urandom), 1'b0, 0, 2);
        run_instr("br0", 5'd18, 27'($urandom), 1'b0, 0, 0);
        run_instr("br1", 5'd18, 27'($urandom), 1'b1, 0, 0);
        run_instr("jr", 5'd19, 27'($urandom), 1'b0, 1, 0);
        run_instr("nop", 5'd25, 27'($urandom), 1'b0, 0, 0);

        for (int i = 0; i < 60; i++) begin
            rop = 5'($urandom_range(0, 25));
            run_instr($sformatf("rnd%0d_op%0d", i, rop), rop, 27'($urandom), 1'($urandom),
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

        run_instr("halt", 5'd26, 27'($urandom), 1'b0, 0, 0);
        reset = 1'b0;
        #1 chk("halt_reset", 27'h0, 4'd0, 1'b0);
        release_reset();
        run_instr("nop2", 5'd25, 27'($urandom), 1'b0, 0, 0);
        run_instr("undef", 5'd31, 27'($urandom), 1'b0, 1, 0);
        reset = 1'b0;
        #1 chk("undef_reset", 27'h0, 4'd0, 1'b0);
        release_reset();
        chk("post_undef:T0", PCOUT | MARIN | INCPC | ZIN, 4'd0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
